voice_alloc: RTL
================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4 (legal 2..8): number of envelope voices managed.
REQ-002 SHALL have parameter NOTE_W, default 7: width of note code.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ev_valid  input  1  note event offered.
REQ-006 SHALL have port ev_ready  output  1  event accepted when ev_valid && ev_ready at a rising edge.
REQ-007 SHALL have port ev_press  input  1  1 = key down, 0 = key up.
REQ-008 SHALL have port ev_note  input  NOTE_W  note code of event.
REQ-009 SHALL have port voice_idle  input  NUM_VOICES  per voice, 1 = envelope generator in IDLE (fully silent).
REQ-010 SHALL have port voice_press  output  NUM_VOICES  per voice press level to envelope generator.
REQ-011 SHALL have port voice_note  output  NUM_VOICES*NOTE_W  note per voice, voice i at bits [i*NOTE_W +: NOTE_W].
REQ-012 SHALL have port busy  output  1  1 whenever FSM not in IDLE.
REQ-013 SHALL have port drop_cnt  output  8  count of press events discarded.

Function
REQ-014 SHALL implement FSM states IDLE, LOOKUP, APPLY, STEAL; ev_ready = 1 only in IDLE.
REQ-015 SHALL, on accept in IDLE, register ev_press/ev_note and go to LOOKUP next cycle.
REQ-016 SHALL in LOOKUP compute: hit = lowest voice with voice_press=1 and voice_note=event note; free = lowest voice with voice_press=0 and voice_idle=1; oldest = voice with age rank 0; then go to APPLY.
REQ-017 SHALL in APPLY for a press with hit: make no change (no retrigger); return to IDLE.
REQ-018 SHALL in APPLY for a press with free voice: set voice_note[free], voice_press[free]=1, make free the newest; return to IDLE; outputs valid 2 cycles after accept edge.
REQ-019 SHALL in APPLY for a press with no hit and no free voice: steal or drop per REQ-030/031.
REQ-020 SHALL in APPLY for a release with hit: clear voice_press[hit]; voice_note retained; no hit: ignore; return to IDLE.
REQ-021 SHALL keep per-voice age rank 0..NUM_VOICES-1, always a permutation; reset rank of voice i = i.
REQ-022 SHALL, when voice v is made newest, set rank[v]=NUM_VOICES-1 and decrement every rank greater than old rank[v] by 1, in one cycle.
REQ-023 SHALL in STEAL hold voice_press[v]=0 for stolen voice v until voice_idle[v]=1, then in that same cycle load voice_note[v], set voice_press[v]=1, make v newest, return to IDLE.
REQ-024 SHALL keep busy=1 and ev_ready=0 throughout STEAL, with no timeout.
REQ-025 SHALL saturate drop_cnt at 255 and never wrap.
REQ-026 SHALL leave voice_press/voice_note of non-targeted voices unchanged in every state.
REQ-027 SHALL use only the registered event; ev_note changes after accept have no effect.

Reset
REQ-028 SHALL, while rst=0, force: state IDLE, voice_press=0, voice_note=0, rank[i]=i, drop_cnt=0, busy=0, ev_ready=0; ev_ready=1 from first edge after rst rises.
REQ-029 SHALL, on reset assertion mid-LOOKUP/APPLY/STEAL, discard the pending event immediately (asynchronously), with no partial voice update.

Configuration
REQ-030 SHALL, with macro VOICE_ALLOC_STEAL_EN defined, on press with no hit and no free voice go from APPLY to STEAL targeting oldest voice; drop_cnt unchanged.
REQ-031 SHALL, without VOICE_ALLOC_STEAL_EN, omit STEAL state and logic; such a press increments drop_cnt and returns to IDLE with voices untouched.

Verification
REQ-032 SHALL verify: reset, all voice_idle=1, press note 60 -> voice_press=0001, voice_note[0]=60 two cycles after accept, busy high 2 cycles.
REQ-033 SHALL verify: press 60,62,64,65 then press 60 again -> voice_press=1111, no retrigger, drop_cnt=0.
REQ-034 SHALL verify: release 62 with voices 60/62/64/65 -> voice_press=1101; release 70 -> no change.
REQ-035 SHALL verify with STEAL_EN: 4 voices held (voice_idle=0), press 67 -> voice_press[0]=0 until voice_idle[0]=1 driven 5 cycles later, then voice_press[0]=1, voice_note[0]=67, rank[0]=3.
REQ-036 SHALL verify without STEAL_EN: same stimulus x300 -> voices unchanged, drop_cnt=255 saturated.
REQ-037 SHALL verify: rst=0 asserted during STEAL -> all outputs at reset values immediately, ev_ready=1 one edge after release.

Source files
------------

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator (hit/free lookup, age ranks, optional oldest-voice stealing).
// Define VOICE_ALLOC_STEAL_EN to steal the oldest voice instead of dropping presses when all voices are busy.
`timescale 1ns/1ps
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_press,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        voice_idle,
    output logic [NUM_VOICES-1:0]        voice_press,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         busy,
    output logic [7:0]                   drop_cnt
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    typedef logic [VW-1:0] vidx_t;
`ifdef VOICE_ALLOC_STEAL_EN
    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, STEAL} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;
`endif
    state_t                      state_q, state_d;
    logic                        ready_q, ready_d, busy_q, busy_d, press_q, press_d;
    logic [NOTE_W-1:0]           note_q, note_d;
    logic [NUM_VOICES-1:0]       vpress_q, vpress_d;
    logic [NUM_VOICES*NOTE_W-1:0] vnote_q, vnote_d;
    logic [7:0]                  drop_q, drop_d;
    vidx_t                       rank_q [NUM_VOICES];
    vidx_t                       rank_d [NUM_VOICES];
    logic                        hit_q, hit_d, free_q, free_d, hit_c, free_c;
    vidx_t                       hit_v_q, hit_v_d, free_v_q, free_v_d, hit_v_c, free_v_c;
    logic                        newest_en;
    vidx_t                       newest_v;
`ifdef VOICE_ALLOC_STEAL_EN
    vidx_t                       old_v_q, old_v_d, old_v_c;
`endif

    assign ev_ready    = ready_q;
    assign busy        = busy_q;
    assign voice_press = vpress_q;
    assign voice_note  = vnote_q;
    assign drop_cnt    = drop_q;

    // Descending scan so the lowest matching voice wins.
    always_comb begin
        hit_c    = 1'b0;
        hit_v_c  = '0;
        free_c   = 1'b0;
        free_v_c = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        old_v_c  = '0;
`endif
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (vpress_q[i] && vnote_q[i*NOTE_W +: NOTE_W] == note_q) begin
                hit_c   = 1'b1;
                hit_v_c = vidx_t'(i);
            end
            if (!vpress_q[i] && voice_idle[i]) begin
                free_c   = 1'b1;
                free_v_c = vidx_t'(i);
            end
`ifdef VOICE_ALLOC_STEAL_EN
            if (rank_q[i] == '0) old_v_c = vidx_t'(i);
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++)
            rank_d[i] = !newest_en ? rank_q[i] :
                        (vidx_t'(i) == newest_v) ? vidx_t'(NUM_VOICES - 1) :
                        (rank_q[i] > rank_q[newest_v]) ? rank_q[i] - vidx_t'(1) : rank_q[i];
    end

    always_comb begin
        state_d   = state_q;
        press_d   = press_q;
        note_d    = note_q;
        vpress_d  = vpress_q;
        vnote_d   = vnote_q;
        drop_d    = drop_q;
        hit_d     = hit_q;
        hit_v_d   = hit_v_q;
        free_d    = free_q;
        free_v_d  = free_v_q;
        newest_en = 1'b0;
        newest_v  = free_v_q;
`ifdef VOICE_ALLOC_STEAL_EN
        old_v_d   = old_v_q;
`endif
        case (state_q)
            IDLE: if (ev_valid && ready_q) begin
                press_d = ev_press;
                note_d  = ev_note;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                hit_d    = hit_c;
                hit_v_d  = hit_v_c;
                free_d   = free_c;
                free_v_d = free_v_c;
`ifdef VOICE_ALLOC_STEAL_EN
                old_v_d  = old_v_c;
`endif
                state_d  = APPLY;
            end
            APPLY: begin
                state_d = IDLE;
                if (press_q && !hit_q) begin
                    if (free_q) begin
                        vpress_d[free_v_q]                  = 1'b1;
                        vnote_d[free_v_q*NOTE_W +: NOTE_W] = note_q;
                        newest_en                           = 1'b1;
                    end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                        vpress_d[old_v_q] = 1'b0;
                        state_d           = STEAL;
`else
                        drop_d = (drop_q == 8'hff) ? drop_q : drop_q + 8'd1;
`endif
                    end
                end else if (!press_q && hit_q) begin
                    vpress_d[hit_v_q] = 1'b0;
                end
            end
`ifdef VOICE_ALLOC_STEAL_EN
            // Victim stays released until its envelope has fully decayed.
            STEAL: if (voice_idle[old_v_q]) begin
                vpress_d[old_v_q]                  = 1'b1;
                vnote_d[old_v_q*NOTE_W +: NOTE_W] = note_q;
                newest_en                          = 1'b1;
                newest_v                           = old_v_q;
                state_d                            = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            press_q  <= 1'b0;
            note_q   <= '0;
            vpress_q <= '0;
            vnote_q  <= '0;
            drop_q   <= '0;
            hit_q    <= 1'b0;
            hit_v_q  <= '0;
            free_q   <= 1'b0;
            free_v_q <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            old_v_q  <= '0;
`endif
            for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= vidx_t'(i);
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            press_q  <= press_d;
            note_q   <= note_d;
            vpress_q <= vpress_d;
            vnote_q  <= vnote_d;
            drop_q   <= drop_d;
            hit_q    <= hit_d;
            hit_v_q  <= hit_v_d;
            free_q   <= free_d;
            free_v_q <= free_v_d;
`ifdef VOICE_ALLOC_STEAL_EN
            old_v_q  <= old_v_d;
`endif
            rank_q   <= rank_d;
        end
    end
endmodule
